sub_nibble_serial: RTL

- Multi-cycle unsigned/two's-complement subtractor. Computes D = A - B over a W = 4*NIBBLES bit word, one 4-bit carry-lookahead slice per clock, least-significant nibble first.
- It is the subtract counterpart to the team's 4-bit CLA adder. It lets narrow datapaths handle wide compare/subtract operations with a small area cost.
- Uses a start/done handshake so a controller can queue one operation at a time.

---
 rtl/sub_nibble_serial_if.sv | 27 ++
 rtl/sub_nibble_serial.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sub_nibble_serial_if.sv
// Start/done handshake and result bus for the nibble-serial subtractor.
// The master drives the request, the slave returns the difference and flags.
interface sub_nibble_serial_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] D;
  logic         bout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, A, B,
    input  ready, done, D, bout, ovf, zero
  );

  modport slave (
    input  start, A, B,
    output ready, done, D, bout, ovf, zero
  );
endinterface

// File: rtl/sub_nibble_serial.sv
// Multi-cycle subtractor: D = A - B, one 4-bit lookahead slice per clock,
// least-significant nibble first, with borrow, overflow and zero flags.
module sub_nibble_serial #(
  parameter int NIBBLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sub_nibble_serial_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  d_q;
  logic          carry;
  logic [KW-1:0] k;
  logic          ready_q;
  logic          done_q;
  logic          bout_q;
  logic          ovf_q;
  logic          zero_q;

  int            idx;
  logic [3:0]    a_s;
  logic [3:0]    nb;
  logic [3:0]    p;
  logic [3:0]    g;
  logic [4:0]    c;
  logic [3:0]    s;
  logic [W-1:0]  d_new;
  logic          last;

  // One lookahead slice: A + ~B + carry, carry seeded with 1 on start.
  always_comb begin
    idx   = 4 * int'(k);
    a_s   = a_q[idx +: 4];
    nb    = ~b_q[idx +: 4];
    p     = a_s ^ nb;
    g     = a_s & nb;
    c[0]  = carry;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0])
          | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s     = p ^ c[3:0];
    d_new = d_q;
    d_new[idx +: 4] = s;
    last  = (k == KW'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      carry   <= 1'b0;
      k       <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry   <= 1'b1;
            k       <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          d_q   <= d_new;
          carry <= c[4];
          k     <= k + KW'(1);
          if (last) begin
            state  <= DONE;
            done_q <= 1'b1;
            bout_q <= ~c[4];
            ovf_q  <= (a_q[W-1] != b_q[W-1])
                   && (d_new[W-1] != a_q[W-1]);
            zero_q <= (d_new == '0);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.D     = d_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
endmodule
